// File: rtl/rx_block_fifo.sv
// rx_block_fifo: packs UART bytes into 128-bit blocks, queues DEPTH blocks; push visible one edge after 16th byte.
// No backpressure on rx: a block completing while full is dropped and flags overflow. Define RX_BYTE_TIMEOUT_EN for idle discard of partial blocks.
module rx_block_fifo #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic                   rx_read,
  input  logic                   overflow_clr,
  output logic [127:0]           pt,
  output logic                   rx_empty,
  output logic                   rx_full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [3:0]    cnt_q, cnt_d;
  logic [127:0]  sr_q, sr_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic          ovf_q, ovf_d;
  logic [127:0]  mem [DEPTH];

  logic [127:0]  blk;
  logic          push, pop, accept, tmo;

  assign blk      = {sr_q[119:0], rx_data};
  assign rx_empty = (lvl_q == '0);
  assign rx_full  = (lvl_q == DEPTH_L);
  assign push     = rx_valid && (cnt_q == 4'd15);
  assign pop      = rx_read && !rx_empty;
  // A full FIFO still takes the block when the head leaves in the same cycle.
  assign accept   = push && (!rx_full || pop);

  assign pt       = rx_empty ? '0 : mem[rd_q];
  assign level    = lvl_q;
  assign overflow = ovf_q;

`ifdef RX_BYTE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_q, idle_d;

  always_comb begin
    idle_d = '0;
    tmo    = 1'b0;
    if (!rx_valid && (cnt_q != 4'd0)) begin
      if (idle_q == TW'(TIMEOUT_CYCLES - 1)) tmo = 1'b1;
      else idle_d = idle_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) idle_q <= '0;
    else        idle_q <= idle_d;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    ovf_d = ovf_q;
    if (rx_valid) begin
      cnt_d = cnt_q + 4'd1;
      sr_d  = blk;
    end
    if (tmo) cnt_d = 4'd0;
    if (accept) wr_d = wr_q + PW'(1);
    if (pop)    rd_d = rd_q + PW'(1);
    case ({accept, pop})
      2'b10:   lvl_d = lvl_q + LW'(1);
      2'b01:   lvl_d = lvl_q - LW'(1);
      default: lvl_d = lvl_q;
    endcase
    if (overflow_clr)       ovf_d = 1'b0;
    if (push && !accept)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      sr_q  <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
      ovf_q <= ovf_d;
    end
  end

  // Storage is not reset; pt is masked while empty so stale slots never show.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_q] <= blk;
  end

endmodule

// File: tb/tb_rx_block_fifo.sv
// Bench for rx_block_fifo: table vectors, directed corner sequences, and random traffic against a queue model.
module tb_rx_block_fifo;
  localparam int DEPTH = 4;
  localparam int TMO   = 50;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [7:0]   rx_data = '0;
  logic         rx_valid = 1'b0;
  logic         rx_read = 1'b0;
  logic         overflow_clr = 1'b0;
  logic [127:0] pt;
  logic         rx_empty, rx_full, overflow;
  logic [2:0]   level;

  rx_block_fifo #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_read(rx_read), .overflow_clr(overflow_clr), .pt(pt),
    .rx_empty(rx_empty), .rx_full(rx_full), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: list of complete blocks, list of pending bytes.
  logic [127:0] q[$];
  logic [7:0]   part[$];
  logic         m_ovf = 1'b0;
  int           m_idle = 0;

  task automatic model_step(input logic vld, input logic [7:0] dat, input logic rd, input logic clr);
    bit full;
    bit pop_ok;
    logic [127:0] b;
    full   = (q.size() == DEPTH);
    pop_ok = rd && (q.size() > 0);
    if (pop_ok) void'(q.pop_front());
    if (clr) m_ovf = 1'b0;
    if (vld) begin
      part.push_back(dat);
      m_idle = 0;
      if (part.size() == 16) begin
        b = '0;
        foreach (part[i]) b = {b[119:0], part[i]};
        if (!full || pop_ok) q.push_back(b);
        else m_ovf = 1'b1;
        part.delete();
      end
    end
`ifdef RX_BYTE_TIMEOUT_EN
    else if (part.size() > 0) begin
      m_idle++;
      if (m_idle == TMO) begin
        part.delete();
        m_idle = 0;
      end
    end
`endif
  endtask

  task automatic cyc(input logic vld, input logic [7:0] dat, input logic rd, input logic clr);
    rx_valid = vld; rx_data = dat; rx_read = rd; overflow_clr = clr;
    model_step(vld, dat, rd, clr);
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_read = 1'b0; overflow_clr = 1'b0;
  endtask

  task automatic check_exp(input string nm, input logic e_empty, input logic e_full,
                           input logic [2:0] e_level, input logic e_ovf, input logic [127:0] e_pt);
    vectors++;
    if (rx_empty !== e_empty || rx_full !== e_full || level !== e_level ||
        overflow !== e_ovf || pt !== e_pt) begin
      miscompares++;
      $display("FAIL %s: got empty=%b full=%b level=%0d ovf=%b pt=%h ; want empty=%b full=%b level=%0d ovf=%b pt=%h",
               nm, rx_empty, rx_full, level, overflow, pt, e_empty, e_full, e_level, e_ovf, e_pt);
    end
  endtask

  task automatic check_model(input string nm);
    logic [127:0] head;
    head = (q.size() > 0) ? q[0] : '0;
    check_exp(nm, q.size() == 0, q.size() == DEPTH, 3'(q.size()), m_ovf, head);
  endtask

  function automatic logic [127:0] mkblk(input logic [7:0] base);
    logic [127:0] b;
    b = '0;
    for (int i = 0; i < 16; i++) b = {b[119:0], base + 8'(i)};
    return b;
  endfunction

  task automatic send_bytes(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, base + 8'(i), 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    #2;
    q.delete(); part.delete(); m_ovf = 1'b0; m_idle = 0;
    check_exp("reset_async", 1'b1, 1'b0, 3'd0, 1'b0, '0);
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  typedef struct {
    logic         vld;
    logic [7:0]   dat;
    logic         rd;
    logic         clr;
    logic         e_empty;
    logic [2:0]   e_level;
    logic         e_ovf;
    logic [127:0] e_pt;
  } vec_t;

  vec_t tbl[18];

  initial begin
    logic [127:0] exp37;
    logic vld, rd, clr;
    int rd_pct, vld_pct;

    tbl[0] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 128'h0};
    for (int i = 0; i < 16; i++)
      tbl[i+1] = '{1'b1, 8'(i), 1'b0, 1'b0, (i != 15), (i == 15) ? 3'd1 : 3'd0, 1'b0,
                   (i == 15) ? 128'h000102030405060708090A0B0C0D0E0F : 128'h0};
    tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 128'h0};

    // Reset state, then release so the next edge is live.
    repeat (2) @(posedge clk);
    #1;
    check_exp("reset_state", 1'b1, 1'b0, 3'd0, 1'b0, '0);
    reset = 1'b1;

    for (int k = 0; k < 18; k++) begin
      cyc(tbl[k].vld, tbl[k].dat, tbl[k].rd, tbl[k].clr);
      check_exp($sformatf("tbl%0d", k), tbl[k].e_empty, 1'b0, tbl[k].e_level, tbl[k].e_ovf, tbl[k].e_pt);
    end

    // Push and pop together while empty: pop ignored.
    send_bytes(8'h20, 15);
    cyc(1'b1, 8'h2F, 1'b1, 1'b0);
    check_exp("push_pop_empty", 1'b0, 1'b0, 3'd1, 1'b0, mkblk(8'h20));
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check_exp("pop_to_empty", 1'b1, 1'b0, 3'd0, 1'b0, '0);

    // Overflow on a full FIFO.
    do_reset();
    send_bytes(8'h30, 16);
    send_bytes(8'h40, 16);
    send_bytes(8'h50, 16);
    send_bytes(8'h60, 16);
    check_exp("fill_full", 1'b0, 1'b1, 3'd4, 1'b0, mkblk(8'h30));
    send_bytes(8'h70, 16);
    check_exp("overflow_drop", 1'b0, 1'b1, 3'd4, 1'b1, mkblk(8'h30));
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check_exp("overflow_clr", 1'b0, 1'b1, 3'd4, 1'b0, mkblk(8'h30));
    send_bytes(8'h80, 15);
    cyc(1'b1, 8'h8F, 1'b0, 1'b1);
    check_exp("drop_beats_clr", 1'b0, 1'b1, 3'd4, 1'b1, mkblk(8'h30));
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check_model("clr_again");

    // Push and pop together while full.
    send_bytes(8'h90, 15);
    cyc(1'b1, 8'h9F, 1'b1, 1'b0);
    check_exp("push_pop_full", 1'b0, 1'b1, 3'd4, 1'b0, mkblk(8'h40));
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check_exp("pop_mid", 1'b0, 1'b0, 3'd2, 1'b0, mkblk(8'h60));
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check_exp("fifth_at_head", 1'b0, 1'b0, 3'd1, 1'b0, mkblk(8'h90));
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check_exp("pop_empty_ignored", 1'b1, 1'b0, 3'd0, 1'b0, '0);

    // Reset mid-block discards the partial bytes.
    send_bytes(8'hC0, 7);
    do_reset();
    send_bytes(8'h10, 16);
    check_exp("reset_mid_block", 1'b0, 1'b0, 3'd1, 1'b0, 128'h101112131415161718191A1B1C1D1E1F);

    // Idle gap on a partial block.
    do_reset();
    send_bytes(8'h55, 5);
    repeat (50) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    send_bytes(8'hA0, 16);
`ifdef RX_BYTE_TIMEOUT_EN
    exp37 = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
`else
    exp37 = 128'h5556575859A0A1A2A3A4A5A6A7A8A9AA;
`endif
    check_exp("idle_gap_block", 1'b0, 1'b0, 3'd1, 1'b0, exp37);
    check_model("idle_gap_model");

    // Random traffic in phases of different read pressure.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      case (i / 1000)
        0:       begin rd_pct = 1;  vld_pct = 80; end
        1:       begin rd_pct = 30; vld_pct = 70; end
        2:       begin rd_pct = 70; vld_pct = 90; end
        default: begin rd_pct = 5;  vld_pct = 40; end
      endcase
      if (i % 300 == 150) begin
        repeat (55) begin
          cyc(1'b0, 8'h00, 1'b0, 1'b0);
          check_model("rand_idle");
        end
      end
      vld = ($urandom_range(99) < vld_pct);
      rd  = ($urandom_range(99) < rd_pct);
      clr = ($urandom_range(99) < 3);
      cyc(vld, 8'($urandom), rd, clr);
      check_model($sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
